uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, serial bit rate in bits/s.
REQ-003 SHALL have parameter PARITY, default "NONE", one of "NONE", "EVEN" or "ODD".
REQ-004 SHALL have parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-005 SHALL have port clk, input, 1 bit, sole clock; all logic rising-edge.
REQ-006 SHALL have port rst, input, 1 bit, reset: asynchronous, active-high.
REQ-007 SHALL have port tx_data, input, 8 bits, byte to transmit.
REQ-008 SHALL have port tx_valid, input, 1 bit, tx_data valid.
REQ-009 SHALL have port tx_ready, output, 1 bit, block accepts a byte this cycle.
REQ-010 SHALL have port tx_busy, output, 1 bit, a frame is in progress.
REQ-011 SHALL have port uart_txd, output, 1 bit, serial line, idle high.

Function
REQ-012 SHALL derive CLKS_PER_BIT = CLK_FREQ / BAUD_RATE, integer truncation (868 at defaults), and hold every serial bit for exactly CLKS_PER_BIT clocks.
REQ-013 SHALL elaborate-time error if CLKS_PER_BIT < 2, PARITY is illegal, or STOP_BITS is not 1 or 2.
REQ-014 SHALL implement the states IDLE, START, DATA, PARITY, STOP.
REQ-015 SHALL transfer a byte when tx_valid and tx_ready are both high on a rising clk edge, latching tx_data into a shift register.
REQ-016 SHALL drive tx_ready high in IDLE and, combinationally, in the final clock of the final stop bit; low otherwise.
REQ-017 SHALL hold tx_data stable internally after acceptance; later changes on tx_data SHALL NOT affect the frame in progress.
REQ-018 SHALL go from IDLE to START on acceptance, driving uart_txd low from the next cycle for CLKS_PER_BIT clocks.
REQ-019 SHALL in DATA send 8 bits LSB first, using a 3-bit index that counts 0..7.
REQ-020 SHALL enter PARITY after bit 7 only when PARITY != "NONE", sending the XOR of the 8 bits for "EVEN" or its inverse for "ODD".
REQ-021 SHALL in STOP drive uart_txd high for STOP_BITS*CLKS_PER_BIT clocks.
REQ-022 SHALL, on acceptance in the final stop-bit clock, enter START directly with no idle clock between frames; otherwise it SHALL return to IDLE.
REQ-023 SHALL assert tx_busy in every state except IDLE.
REQ-024 SHALL make an 8N1 frame exactly 10*CLKS_PER_BIT clocks long, and an 8E2 frame exactly 12*CLKS_PER_BIT.
REQ-025 SHALL ignore tx_valid when tx_ready is low; no byte is queued or dropped silently because the sender must hold tx_valid.
REQ-026 SHALL register uart_txd so it is glitch-free.

Reset
REQ-027 SHALL on rst assertion immediately force the state to IDLE, uart_txd=1, tx_busy=0, tx_ready=0, and clear the baud counter, bit index and shift register.
REQ-028 SHALL hold tx_ready=0 while rst is high and assert it on the first rising clk after deassertion.
REQ-029 SHALL abort a frame in progress when rst asserts mid-frame, releasing the line high with no partial resumption.

Structure
REQ-030 SHALL place the parity-mode enum and a clks_per_bit(clk_freq, baud_rate) function in the shared uart_pkg.
REQ-031 SHALL use one sub-module, uart_baud_cnt: a load/enable counter with a terminal-count pulse every CLKS_PER_BIT clocks, restartable on frame start.
REQ-032 SHALL be sized so that RTL, excluding the package, is 120-400 lines.

Verification
REQ-033 Single byte: 0x55, 8N1, defaults -> uart_txd = 0,1,0,1,0,1,0,1,0,1, each bit 868 clocks, then high; tx_busy high for exactly 8680 clocks.
REQ-034 Back-to-back: tx_valid held high with 0xA5 then 0x3C -> second start bit begins the clock after the first stop bit ends; zero idle clocks.
REQ-035 Parity: PARITY="EVEN", STOP_BITS=2, byte 0x07 -> parity bit 1, two stop bits, 12*868 clocks total; with "ODD" -> parity bit 0.
REQ-036 Reset mid-frame: assert rst during data bit 3 of 0xFF -> uart_txd=1 and tx_busy=0 with no clock edge; after release, 0x81 transmits correctly.
REQ-037 Loopback: uart_txd wired to uart_rxd of the uart RX path; send a 128-byte random file -> captured bytes match byte-for-byte.
REQ-038 Handshake: vary tx_data while busy, and pulse tx_valid while tx_ready=0 -> transmitted bytes are only the accepted ones, unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Types and helpers shared by the UART transmit path.
//
//   parity_e      : parity mode selected by the PARITY string parameter
//   tx_state_e    : transmitter frame states
//   clks_per_bit  : clock cycles per serial bit, integer-truncated
//   parity_bit    : parity bit value for a byte in the given mode
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Truncating divide: 100 MHz / 115200 gives 868, so the real bit rate
    // sits slightly above nominal, well inside receiver tolerance.
    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // Even parity makes the total count of ones even, so the bit is the XOR
    // of the data; odd parity is its inverse.
    function automatic logic parity_bit(input parity_e mode, input logic [7:0] data);
        return (mode == PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage : uart_pkg

// File: rtl/uart_baud_cnt.sv
// -----------------------------------------------------------------------------
// uart_baud_cnt
//   Bit-period timer. Counts down from CLKS_PER_BIT-1 while enabled and
//   pulses tc on the last clock of every bit period. load restarts the
//   period so a new frame always begins on a full-length bit.
//
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset, clears the count
//   load  in   restart a bit period (takes priority over en)
//   en    in   count enable
//   tc    out  terminal count: final clock of the current bit period
// -----------------------------------------------------------------------------
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int              CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: clocked state is assigned with <= so every register samples the
    // pre-edge values; blocking assignments here would create order-dependent
    // simulation and a mismatch against the synthesised netlist.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_TOP;
        end else if (en) begin
            cnt <= (cnt == '0) ? CNT_TOP : cnt - 1'b1;
        end
    end

    // Combinational so the FSM can act in the same clock as the last count.
    assign tc = en && (cnt == '0);

endmodule : uart_baud_cnt

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   8-bit UART transmitter: start bit, 8 data bits LSB first, optional
//   even/odd parity bit, 1 or 2 stop bits. Valid/ready byte handshake with
//   back-to-back frames when a byte is offered during the last stop clock.
//
//   Parameters
//     CLK_FREQ   input clock frequency in Hz
//     BAUD_RATE  serial bit rate in bits/s
//     PARITY     "NONE", "EVEN" or "ODD"
//     STOP_BITS  1 or 2
//
//   Ports
//     clk       in   sole clock, rising edge
//     rst       in   asynchronous active-high reset; aborts any frame
//     tx_data   in   [7:0] byte to transmit
//     tx_valid  in   tx_data is valid
//     tx_ready  out  a byte is accepted on this clock if tx_valid is high
//     tx_busy   out  a frame is in progress
//     uart_txd  out  registered serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int    CLK_FREQ  = 100_000_000,
    parameter int    BAUD_RATE = 115_200,
    parameter string PARITY    = "NONE",
    parameter int    STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       uart_txd
);

    localparam int      CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam bit      PARITY_OK    = (PARITY == "NONE") || (PARITY == "EVEN") || (PARITY == "ODD");
    localparam parity_e PAR_MODE     = (PARITY == "EVEN") ? PAR_EVEN :
                                       (PARITY == "ODD")  ? PAR_ODD  : PAR_NONE;
    // Index of the last stop bit: 0 for one stop bit, 1 for two.
    localparam logic    STOP_LAST    = (STOP_BITS == 2);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    if (CLKS_PER_BIT < 2) begin : g_bad_rate
        $error("uart_tx: CLK_FREQ / BAUD_RATE must be at least 2");
    end
    if (!PARITY_OK) begin : g_bad_parity
        $error("uart_tx: PARITY must be \"NONE\", \"EVEN\" or \"ODD\"");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    tx_state_e  state;
    logic [7:0] shift_q;    // remaining data bits, next bit in [0]
    logic [2:0] bit_idx;    // data bit currently on the line, 0..7
    logic       stop_idx;   // stop bit currently on the line
    logic       par_q;      // parity of the accepted byte
    logic       ready_en;   // low until the first clock after reset
    logic       txd_q;
    logic       busy_q;

    logic       baud_tc;
    logic       last_stop;
    logic       accept;

    // -------------------------------------------------------------------------
    // Bit timer: restarted on every accepted byte, free-running within a frame
    // -------------------------------------------------------------------------
    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .en   (state != ST_IDLE),
        .tc   (baud_tc)
    );

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    assign last_stop = (state == ST_STOP) && baud_tc && (stop_idx == STOP_LAST);

    // NOTE: tx_ready is deliberately combinational from registered state so a
    // byte can be taken in the very last stop clock and the next start bit
    // follows with no idle clock. It never depends on tx_valid, so there is
    // no combinational loop through the sender.
    assign tx_ready = ready_en && ((state == ST_IDLE) || last_stop);
    assign accept   = tx_valid && tx_ready;

    // -------------------------------------------------------------------------
    // Frame FSM. Acceptance only happens in IDLE or the last stop clock, so
    // it is handled ahead of the per-state bit sequencing.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            shift_q  <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par_q    <= 1'b0;
            ready_en <= 1'b0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            ready_en <= 1'b1;

            if (accept) begin
                // Byte and its parity are captured here; tx_data is not looked
                // at again until the next acceptance.
                state   <= ST_START;
                shift_q <= tx_data;
                par_q   <= parity_bit(PAR_MODE, tx_data);
                bit_idx <= '0;
                txd_q   <= 1'b0;
                busy_q  <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        txd_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end

                    ST_START: begin
                        if (baud_tc) begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                            txd_q   <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end

                    ST_DATA: begin
                        if (baud_tc) begin
                            if (bit_idx == 3'd7) begin
                                if (PAR_MODE != PAR_NONE) begin
                                    state <= ST_PARITY;
                                    txd_q <= par_q;
                                end else begin
                                    state    <= ST_STOP;
                                    stop_idx <= 1'b0;
                                    txd_q    <= 1'b1;
                                end
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                                txd_q   <= shift_q[0];
                                shift_q <= shift_q >> 1;
                            end
                        end
                    end

                    ST_PARITY: begin
                        if (baud_tc) begin
                            state    <= ST_STOP;
                            stop_idx <= 1'b0;
                            txd_q    <= 1'b1;
                        end
                    end

                    ST_STOP: begin
                        if (baud_tc) begin
                            if (stop_idx == STOP_LAST) begin
                                state  <= ST_IDLE;
                                busy_q <= 1'b0;
                            end else begin
                                stop_idx <= 1'b1;
                            end
                        end
                    end

                    default: begin
                        state  <= ST_IDLE;
                        txd_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign uart_txd = txd_q;
    assign tx_busy  = busy_q;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//   Four transmitters: defaults (8N1 @ 868 clk/bit), 8E2 and 8O2 at 868
//   clk/bit, and a fast 8N1 at 10 clk/bit for the loopback and handshake runs.
//   Senders push each accepted byte into a per-instance queue; a serial
//   monitor per instance detects each start bit, pops the expected byte and
//   compares every line sample of the frame against the ideal waveform, then
//   compares the byte it decoded at mid-bit.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int NK       = 4;
    localparam int CPB_DEF  = 868;
    localparam int CPB_FAST = 10;

    typedef struct {
        logic [7:0] data;
        bit         abort;
    } exp_t;

    logic            clk = 1'b0;
    logic [NK-1:0]   rst_v;
    logic [NK-1:0]   valid_v;
    logic [NK-1:0]   ready_v;
    logic [NK-1:0]   busy_v;
    logic [NK-1:0]   txd_v;
    logic [7:0]      data_v [NK];

    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    exp_t exp_q     [NK][$];
    int   start_cyc [NK][$];
    logic cap_par   [NK];

    int cfg_cpb  [NK] = '{CPB_DEF, CPB_DEF, CPB_DEF, CPB_FAST};
    int cfg_par  [NK] = '{0, 1, 2, 0};   // 0 none, 1 even, 2 odd
    int cfg_stop [NK] = '{1, 2, 2, 1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx u_def (
        .clk(clk), .rst(rst_v[0]), .tx_data(data_v[0]), .tx_valid(valid_v[0]),
        .tx_ready(ready_v[0]), .tx_busy(busy_v[0]), .uart_txd(txd_v[0])
    );

    uart_tx #(.PARITY("EVEN"), .STOP_BITS(2)) u_even (
        .clk(clk), .rst(rst_v[1]), .tx_data(data_v[1]), .tx_valid(valid_v[1]),
        .tx_ready(ready_v[1]), .tx_busy(busy_v[1]), .uart_txd(txd_v[1])
    );

    uart_tx #(.PARITY("ODD"), .STOP_BITS(2)) u_odd (
        .clk(clk), .rst(rst_v[2]), .tx_data(data_v[2]), .tx_valid(valid_v[2]),
        .tx_ready(ready_v[2]), .tx_busy(busy_v[2]), .uart_txd(txd_v[2])
    );

    uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000)) u_fast (
        .clk(clk), .rst(rst_v[3]), .tx_data(data_v[3]), .tx_valid(valid_v[3]),
        .tx_ready(ready_v[3]), .tx_busy(busy_v[3]), .uart_txd(txd_v[3])
    );

    // -------------------------------------------------------------------------
    // Comparison helper
    // -------------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Offer a byte; it is queued as expected only on the clock it is taken.
    task automatic send(input int k, input logic [7:0] d, input bit keep, input bit abort_exp);
        exp_t e;
        bit   done;
        done = 1'b0;
        @(negedge clk);
        data_v[k]  = d;
        valid_v[k] = 1'b1;
        for (int n = 0; n < 40 * cfg_cpb[k] && !done; n++) begin
            if (n != 0) @(negedge clk);
            if (ready_v[k] === 1'b1) begin
                e.data  = d;
                e.abort = abort_exp;
                exp_q[k].push_back(e);
                done = 1'b1;
            end
        end
        check($sformatf("accept_%0d_%02h", k, d), 32'(done), 32'd1);
        @(posedge clk);
        #1;
        if (!keep) valid_v[k] = 1'b0;
    endtask

    // Called just after acceptance: counts clocks with tx_busy high.
    task automatic busy_len(input int k, input int want, input string name);
        int n;
        n = 0;
        for (int i = 0; i < want + 100; i++) begin
            @(negedge clk);
            if (busy_v[k] !== 1'b1) break;
            n++;
        end
        check(name, 32'(n), 32'(want));
    endtask

    task automatic wait_drain(input int k);
        int n;
        n = 0;
        while ((exp_q[k].size() != 0 || busy_v[k] !== 1'b0) && n < 30 * cfg_cpb[k]) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("drain_busy_%0d", k), 32'(busy_v[k]), 32'd0);
        check($sformatf("drain_queue_%0d", k), 32'(exp_q[k].size()), 32'd0);
    endtask

    // -------------------------------------------------------------------------
    // Serial monitor: one per instance
    // -------------------------------------------------------------------------
    task automatic monitor(input int k);
        exp_t       e;
        logic       frame [16];
        logic [7:0] cap;
        int         nb;
        int         errs;
        int         first_bad;
        int         cpb;
        cpb = cfg_cpb[k];
        forever begin
            @(negedge clk);
            if (rst_v[k] !== 1'b0 || txd_v[k] !== 1'b0) continue;
            start_cyc[k].push_back(cyc);
            if (exp_q[k].size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL frame_%0d: start bit at cycle %0d, want no frame (nothing accepted)", k, cyc);
                for (int n = 0; n < 20 * cpb && txd_v[k] === 1'b0; n++) @(negedge clk);
                continue;
            end
            e = exp_q[k].pop_front();
            if (e.abort) begin
                for (int n = 0; n < 20 * cpb && rst_v[k] !== 1'b1; n++) @(negedge clk);
                while (rst_v[k] === 1'b1) @(negedge clk);
                continue;
            end
            nb = 0;
            frame[nb] = 1'b0; nb++;
            for (int i = 0; i < 8; i++) begin
                frame[nb] = e.data[i]; nb++;
            end
            if (cfg_par[k] == 1) begin frame[nb] = ^e.data;    nb++; end
            if (cfg_par[k] == 2) begin frame[nb] = ~(^e.data); nb++; end
            for (int s = 0; s < cfg_stop[k]; s++) begin
                frame[nb] = 1'b1; nb++;
            end
            errs      = 0;
            first_bad = -1;
            cap       = '0;
            for (int i = 0; i < nb; i++) begin
                for (int c = 0; c < cpb; c++) begin
                    if (i != 0 || c != 0) @(negedge clk);
                    if (txd_v[k] !== frame[i]) begin
                        if (errs == 0) first_bad = i;
                        errs++;
                    end
                    if (c == cpb / 2) begin
                        if (i >= 1 && i <= 8) cap[i-1] = txd_v[k];
                        if (cfg_par[k] != 0 && i == 9) cap_par[k] = txd_v[k];
                    end
                end
            end
            n_vec++;
            if (errs != 0 || cap !== e.data) begin
                n_err++;
                $display("FAIL frame_%0d: got byte 0x%02h with %0d bad line samples (first in bit slot %0d), want byte 0x%02h",
                         k, cap, errs, first_bad, e.data);
            end
        end
    endtask

    for (genvar g = 0; g < NK; g++) begin : g_mon
        initial monitor(g);
    end

    // -------------------------------------------------------------------------
    // Per-instance stimulus threads
    // -------------------------------------------------------------------------
    task automatic thread_def();
        int s0;
        // Single byte, 8N1: ten bits of 868 clocks, busy for 8680 clocks.
        send(0, 8'h55, 1'b0, 1'b0);
        busy_len(0, 10 * CPB_DEF, "busy_len_55");
        wait_drain(0);

        // Back-to-back with tx_valid held: second start right after first stop.
        s0 = start_cyc[0].size();
        send(0, 8'hA5, 1'b1, 1'b0);
        send(0, 8'h3C, 1'b0, 1'b0);
        wait_drain(0);
        check("b2b_frames", 32'(start_cyc[0].size() - s0), 32'd2);
        if (start_cyc[0].size() >= s0 + 2)
            check("b2b_start_spacing", 32'(start_cyc[0][s0+1] - start_cyc[0][s0]), 32'(10 * CPB_DEF));

        // Reset during data bit 3 of 0xFF: line high and busy low with no edge.
        send(0, 8'hFF, 1'b0, 1'b1);
        repeat (4 * CPB_DEF + CPB_DEF / 2) @(posedge clk);
        #2;
        check("busy_before_rst", 32'(busy_v[0]), 32'd1);
        rst_v[0] = 1'b1;
        #1;
        check("rst_async_txd", 32'(txd_v[0]), 32'd1);
        check("rst_async_busy", 32'(busy_v[0]), 32'd0);
        check("rst_async_ready", 32'(ready_v[0]), 32'd0);
        repeat (3) @(negedge clk);
        check("rst_hold_ready", 32'(ready_v[0]), 32'd0);
        rst_v[0] = 1'b0;
        send(0, 8'h81, 1'b0, 1'b0);
        wait_drain(0);
    endtask

    task automatic thread_parity(input int k, input logic want_par, input string name);
        send(k, 8'h07, 1'b0, 1'b0);
        busy_len(k, 12 * CPB_DEF, {"busy_len_", name});
        wait_drain(k);
        check({"parity_bit_", name}, 32'(cap_par[k]), 32'(want_par));
    endtask

    task automatic thread_fast();
        // Loopback: 128 random bytes streamed back-to-back.
        for (int i = 0; i < 128; i++)
            send(3, 8'($urandom), (i != 127), 1'b0);
        wait_drain(3);
        check("loopback_frames", 32'(start_cyc[3].size()), 32'd128);

        // Handshake: scramble tx_data while busy, pulse tx_valid while not ready.
        for (int b = 0; b < 2; b++) begin
            send(3, (b == 0) ? 8'h5A : 8'hC3, 1'b0, 1'b0);
            for (int n = 0; n < 60; n++) begin
                @(negedge clk);
                data_v[3]  = 8'($urandom);
                valid_v[3] = (ready_v[3] === 1'b0) && (n % 7 == 3);
            end
            @(negedge clk);
            valid_v[3] = 1'b0;
        end
        wait_drain(3);
        repeat (4 * CPB_FAST) @(negedge clk);
        check("handshake_frames", 32'(start_cyc[3].size()), 32'd130);
    endtask

    // -------------------------------------------------------------------------
    // Main sequence
    // -------------------------------------------------------------------------
    initial begin
        rst_v   = '1;
        valid_v = '0;
        for (int k = 0; k < NK; k++) data_v[k] = 8'h00;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NK; k++) begin
            check($sformatf("reset_txd_%0d", k), 32'(txd_v[k]), 32'd1);
            check($sformatf("reset_busy_%0d", k), 32'(busy_v[k]), 32'd0);
            check($sformatf("reset_ready_%0d", k), 32'(ready_v[k]), 32'd0);
        end
        rst_v = '0;
        #1;
        check("ready_before_first_edge", 32'(ready_v[0]), 32'd0);
        @(negedge clk);
        for (int k = 0; k < NK; k++)
            check($sformatf("ready_after_first_edge_%0d", k), 32'(ready_v[k]), 32'd1);

        fork
            thread_def();
            thread_parity(1, 1'b1, "even_07");
            thread_parity(2, 1'b0, "odd_07");
            thread_fast();
        join

        repeat (200) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation reached cycle %0d, want completion before 100000", cyc);
        $fatal(1, "tb_uart_tx watchdog expired");
    end

endmodule : tb_uart_tx
